alu_regbank: RTL and testbench
==============================

# alu_regbank

Memory-mapped register bank that lets a host queue ALU operations for up to NUM_CH independent channels that share one ALU. It sits between the host memory port (enable/rd_wr/addr/wr_data/rd_data) and the ALU operand port (A/B/oper/exec). It adds per-channel operand snapshots, round-robin arbitration, result capture, and sticky status bits.

## Interface
- DATA_WIDTH, 8, operand/result/register width; must be ≥ 8
- NUM_CH, 4, number of channels, 1..8
- ADDR_WIDTH, 5, host address width; must be ≥ 2 + clog2(NUM_CH)

- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  host access strobe; one access per cycle.
- rd_wr  input  1  1 = read, 0 = write.
- addr  input  ADDR_WIDTH  channel index = addr[ADDR_WIDTH-1:2]; register index = addr[1:0].
- wr_data  input  DATA_WIDTH  write data.
- rd_data  output  DATA_WIDTH  registered read data.
- A, B  output  DATA_WIDTH  operands to the ALU.
- oper  output  3  ALU opcode.
- exec  output  1  one-cycle ALU start pulse.
- alu_done  input  1  one-cycle pulse; alu_result is valid with it.
- alu_result  input  DATA_WIDTH  ALU result.
- irq  output  1  present only with ALU_REGBANK_IRQ_EN.

## Operation
- Register map per channel:
  - 0: A (RW)
  - 1: B (RW)
  - 2: CTRL/STATUS
  - 3: RESULT (RO)
- CTRL write fields:
  - [2:0] oper
  - [3] go (self-clearing; never stored)
  - [7] ie (used only with the macro)
- STATUS read fields:
  - [2:0] oper
  - [4] busy
  - [5] done
  - [6] err
  - [7] ie
  - all other bits read 0
- Channel FSM: IDLE → PEND → RUN → IDLE.
  - A write with go=1 in IDLE moves the channel to PEND and clears done and err.
  - Grant moves the channel PEND → RUN.
  - alu_done in RUN returns the channel to IDLE, captures alu_result into RESULT, and sets done.
  - busy = channel in PEND or RUN.
- go written in PEND or RUN: the write is ignored entirely (oper/ie unchanged) and err is set.
- Arbiter:
  - Grants only when no channel is in RUN, so at most one operation is outstanding.
  - Among PEND channels it grants round-robin, starting after the last granted channel; after reset it starts at channel 0.
- On grant, A, B and oper are snapshotted from the granted channel. The outputs hold until the next grant.
- A/B writes during PEND or RUN are accepted. They affect the current operation only if made before the grant.
- alu_done with no channel in RUN is ignored.
- A read of STATUS clears done. If done is set on the same edge, the set wins.
- Writes to RESULT are ignored.
- An access with channel index ≥ NUM_CH reads 0; a write to it has no effect.

## Timing
- Reset values: rd_data=0, A=0, B=0, oper=0, exec=0, irq=0. All channel registers are 0, all channels are IDLE, and the round-robin pointer is 0.
- Read latency is 1 cycle: rd_data is updated at the edge that samples the read and holds until the next read.
- Go latency:
  - A go written at edge N sets PEND at edge N.
  - If the ALU is free, exec is high for exactly one cycle after edge N+1, with A/B/oper valid from the same edge.
- Result latency: alu_done sampled at edge M means RESULT and done are updated at M, and busy reads 0 on a read sampled at M+1.
- A new grant can occur at the edge after alu_done. exec never fires on two consecutive edges.
- Reset mid-operation: all state clears immediately and exec drops. A stale alu_done after reset is ignored.

## Configuration
- ALU_REGBANK_IRQ_EN defined:
  - The irq port exists.
  - irq is registered and equals the OR over channels of (done & ie).
  - It drops one cycle after the last qualifying done clears.
- ALU_REGBANK_IRQ_EN undefined:
  - There is no irq port.
  - ie is not stored and reads 0.

## Test plan
- After reset, read every register of channel 0 → rd_data=0; A/B/oper/exec=0.
- Ch1: write A=0x12 and B=0x34, then CTRL=0x0B (oper=3, go). Expect exec one cycle after edge N+1 with A=0x12, B=0x34, oper=3. Drive alu_done with alu_result=0x46 → RESULT=0x46, then STATUS=0x23. A second STATUS read returns 0x03.
- Write go to ch0, ch2 and ch3 in consecutive cycles while a ch1 operation runs. Expect grant order 2, 3, 0 after ch1 completes, one exec per alu_done.
- Write go=1 twice to ch0 while busy → err=1, with oper from the first write preserved. A later go in IDLE clears err.
- Assert reset while a channel is in RUN, then pulse alu_done → all registers 0 and no done set.
- With ALU_REGBANK_IRQ_EN: set ie on ch3 and complete an operation → irq=1. Read STATUS → irq=0 one cycle later.

Source files
------------

// File: rtl/alu_regbank.sv
// alu_regbank: host register bank queueing ALU operations from NUM_CH channels onto one shared ALU.
// Optional feature macro: ALU_REGBANK_IRQ_EN (adds irq output and per-channel ie storage).
module alu_regbank #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  rd_wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [2:0]            oper,
    output logic                  exec,
    input  logic                  alu_done,
    input  logic [DATA_WIDTH-1:0] alu_result
`ifdef ALU_REGBANK_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned IDX_W = ADDR_WIDTH - 2;

    localparam logic [1:0] REG_A    = 2'd0;
    localparam logic [1:0] REG_B    = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_RES  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_RUN  = 2'd2
    } ch_state_e;

    ch_state_e             r_state  [NUM_CH];
    logic [DATA_WIDTH-1:0] r_a      [NUM_CH];
    logic [DATA_WIDTH-1:0] r_b      [NUM_CH];
    logic [DATA_WIDTH-1:0] r_result [NUM_CH];
    logic [2:0]            r_oper   [NUM_CH];
    logic [NUM_CH-1:0]     r_done;
    logic [NUM_CH-1:0]     r_err;
    logic [CH_W-1:0]       r_rr;

    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] r_a_out;
    logic [DATA_WIDTH-1:0] r_b_out;
    logic [2:0]            r_oper_out;
    logic                  r_exec;

    logic [IDX_W-1:0]      w_idx;
    logic [1:0]            w_reg;
    logic                  w_hit;
    logic [CH_W-1:0]       w_ch;
    logic [NUM_CH-1:0]     w_pend;
    logic [NUM_CH-1:0]     w_busy;
    logic                  w_any_run;
    logic                  w_grant_vld;
    logic                  w_grant;
    logic [CH_W-1:0]       w_grant_ch;
    int unsigned           w_rr_idx;
    logic [NUM_CH-1:0]     w_ie;
    logic [DATA_WIDTH-1:0] w_rd_val;

    assign w_idx = addr[ADDR_WIDTH-1:2];
    assign w_reg = addr[1:0];
    assign w_hit = 32'(w_idx) < NUM_CH;
    assign w_ch  = CH_W'(w_idx);

`ifdef ALU_REGBANK_IRQ_EN
    logic [NUM_CH-1:0] r_ie;
    logic              r_irq;

    assign w_ie = r_ie;
    assign irq  = r_irq;

    // Interrupt enable storage and registered interrupt line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ie  <= '0;
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_done & r_ie);
            if (enable && !rd_wr && w_hit && (w_reg == REG_CTRL)
                && !(wr_data[3] && w_busy[w_ch])) begin
                r_ie[w_ch] <= wr_data[7];
            end
        end
    end
`else
    assign w_ie = '0;
`endif

    // Per-channel occupancy summary.
    always_comb begin
        w_pend    = '0;
        w_busy    = '0;
        w_any_run = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pend[i] = (r_state[i] == ST_PEND);
            w_busy[i] = (r_state[i] != ST_IDLE);
            if (r_state[i] == ST_RUN) begin
                w_any_run = 1'b1;
            end
        end
    end

    // Round-robin search over pending channels, starting at r_rr.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_ch  = '0;
        w_rr_idx    = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_rr_idx = 32'(r_rr) + i;
            if (w_rr_idx >= NUM_CH) begin
                w_rr_idx = w_rr_idx - NUM_CH;
            end
            if (!w_grant_vld && w_pend[CH_W'(w_rr_idx)]) begin
                w_grant_vld = 1'b1;
                w_grant_ch  = CH_W'(w_rr_idx);
            end
        end
    end

    assign w_grant = w_grant_vld && !w_any_run;

    // Host read mux; unmapped channels read as zero.
    always_comb begin
        w_rd_val = '0;
        if (w_hit) begin
            case (w_reg)
                REG_A:    w_rd_val = r_a[w_ch];
                REG_B:    w_rd_val = r_b[w_ch];
                REG_CTRL: w_rd_val = DATA_WIDTH'({w_ie[w_ch], r_err[w_ch], r_done[w_ch],
                                                  w_busy[w_ch], 1'b0, r_oper[w_ch]});
                REG_RES:  w_rd_val = r_result[w_ch];
            endcase
        end
    end

    // Channel registers and state; alu_done is applied after host access so a done-set wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i]  <= ST_IDLE;
                r_a[i]      <= '0;
                r_b[i]      <= '0;
                r_result[i] <= '0;
                r_oper[i]   <= '0;
            end
            r_done <= '0;
            r_err  <= '0;
            r_rr   <= '0;
        end else begin
            if (enable && w_hit) begin
                if (rd_wr) begin
                    if (w_reg == REG_CTRL) begin
                        r_done[w_ch] <= 1'b0;
                    end
                end else begin
                    case (w_reg)
                        REG_A: r_a[w_ch] <= wr_data;
                        REG_B: r_b[w_ch] <= wr_data;
                        REG_CTRL: begin
                            if (!wr_data[3]) begin
                                r_oper[w_ch] <= wr_data[2:0];
                            end else if (w_busy[w_ch]) begin
                                r_err[w_ch] <= 1'b1;
                            end else begin
                                r_oper[w_ch]  <= wr_data[2:0];
                                r_state[w_ch] <= ST_PEND;
                                r_done[w_ch]  <= 1'b0;
                                r_err[w_ch]   <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            for (int i = 0; i < NUM_CH; i++) begin
                if (alu_done && (r_state[i] == ST_RUN)) begin
                    r_state[i]  <= ST_IDLE;
                    r_result[i] <= alu_result;
                    r_done[i]   <= 1'b1;
                end
            end

            if (w_grant) begin
                r_state[w_grant_ch] <= ST_RUN;
                if (32'(w_grant_ch) == NUM_CH - 1) begin
                    r_rr <= '0;
                end else begin
                    r_rr <= w_grant_ch + CH_W'(1);
                end
            end
        end
    end

    // ALU operand snapshot, start pulse and host read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data  <= '0;
            r_a_out    <= '0;
            r_b_out    <= '0;
            r_oper_out <= '0;
            r_exec     <= 1'b0;
        end else begin
            r_exec <= w_grant;
            if (w_grant) begin
                r_a_out    <= r_a[w_grant_ch];
                r_b_out    <= r_b[w_grant_ch];
                r_oper_out <= r_oper[w_grant_ch];
            end
            if (enable && rd_wr) begin
                r_rd_data <= w_rd_val;
            end
        end
    end

    assign rd_data = r_rd_data;
    assign A       = r_a_out;
    assign B       = r_b_out;
    assign oper    = r_oper_out;
    assign exec    = r_exec;

endmodule

// File: tb/tb_alu_regbank.sv
// Bench for alu_regbank: directed vector table, multi-cycle corner sequences,
// and randomized host/ALU traffic against a channel-level reference model.
module tb_alu_regbank;

    localparam int unsigned DW = 8;
    localparam int unsigned NC = 4;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          rd_wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          alu_done = 1'b0;
    logic [DW-1:0] alu_result = '0;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [2:0]    oper;
    logic          exec;
`ifdef ALU_REGBANK_IRQ_EN
    logic          irq;
`endif

    alu_regbank #(.DATA_WIDTH(DW), .NUM_CH(NC), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .rd_wr      (rd_wr),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .A          (A),
        .B          (B),
        .oper       (oper),
        .exec       (exec),
        .alu_done   (alu_done),
        .alu_result (alu_result)
`ifdef ALU_REGBANK_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-channel registers, a pending set and the running channel.
    logic [DW-1:0] m_a   [NC];
    logic [DW-1:0] m_b   [NC];
    logic [DW-1:0] m_res [NC];
    logic [2:0]    m_op  [NC];
    logic          m_ie  [NC];
    logic          m_done[NC];
    logic          m_err [NC];
    logic          m_pend[NC];
    int            m_run;
    int            m_rr;
    logic [DW-1:0] exp_rd, exp_a, exp_b;
    logic [2:0]    exp_op;
    logic          exp_exec, exp_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_a[c] = '0; m_b[c] = '0; m_res[c] = '0; m_op[c] = '0;
            m_ie[c] = 1'b0; m_done[c] = 1'b0; m_err[c] = 1'b0; m_pend[c] = 1'b0;
        end
        m_run = -1; m_rr = 0;
        exp_rd = '0; exp_a = '0; exp_b = '0; exp_op = '0;
        exp_exec = 1'b0; exp_irq = 1'b0;
    endtask

    // One rising edge of the bank, using the inputs currently driven.
    task automatic model_edge();
        int g, ch, rg;
        logic [DW-1:0] ga, gb;
        logic [2:0] gop;
        logic busy, nirq;
        nirq = 1'b0;
        for (int c = 0; c < NC; c++) if (m_done[c] && m_ie[c]) nirq = 1'b1;
        g = -1; ga = '0; gb = '0; gop = '0;
        if (m_run < 0) begin
            for (int i = 0; i < NC; i++) begin
                int c;
                c = (m_rr + i) % NC;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        if (g >= 0) begin ga = m_a[g]; gb = m_b[g]; gop = m_op[g]; end
        ch = int'(addr) / 4;
        rg = int'(addr) % 4;
        if (enable && ch < NC) begin
            busy = m_pend[ch] || (m_run == ch);
            if (rd_wr) begin
                case (rg)
                    0: exp_rd = m_a[ch];
                    1: exp_rd = m_b[ch];
                    2: exp_rd = {m_ie[ch], m_err[ch], m_done[ch], busy, 1'b0, m_op[ch]};
                    default: exp_rd = m_res[ch];
                endcase
                if (rg == 2) m_done[ch] = 1'b0;
            end else begin
                if (rg == 0) m_a[ch] = wr_data;
                if (rg == 1) m_b[ch] = wr_data;
                if (rg == 2) begin
                    if (wr_data[3] && busy) begin
                        m_err[ch] = 1'b1;
                    end else begin
                        m_op[ch] = wr_data[2:0];
`ifdef ALU_REGBANK_IRQ_EN
                        m_ie[ch] = wr_data[7];
`endif
                        if (wr_data[3]) begin
                            m_pend[ch] = 1'b1; m_done[ch] = 1'b0; m_err[ch] = 1'b0;
                        end
                    end
                end
            end
        end else if (enable && rd_wr) begin
            exp_rd = '0;
        end
        if (alu_done && m_run >= 0) begin
            m_res[m_run] = alu_result; m_done[m_run] = 1'b1; m_run = -1;
        end
        exp_exec = 1'b0;
        if (g >= 0) begin
            m_pend[g] = 1'b0; m_run = g; m_rr = (g + 1) % NC;
            exp_a = ga; exp_b = gb; exp_op = gop; exp_exec = 1'b1;
        end
        exp_irq = nirq;
    endtask

    task automatic check_model();
        chk("exec", 32'(exec), 32'(exp_exec));
        chk("A", 32'(A), 32'(exp_a));
        chk("B", 32'(B), 32'(exp_b));
        chk("oper", 32'(oper), 32'(exp_op));
        chk("rd_data", 32'(rd_data), 32'(exp_rd));
`ifdef ALU_REGBANK_IRQ_EN
        chk("irq", 32'(irq), 32'(exp_irq));
`endif
    endtask

    task automatic cyc(input logic en, input logic rw, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd, input logic dn, input logic [DW-1:0] res);
        enable = en; rd_wr = rw; addr = ad; wr_data = wd; alu_done = dn; alu_result = res;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    typedef struct {
        logic          en;
        logic          rw;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        logic          dn;
        logic [DW-1:0] res;
        logic          chk_rd;
        logic [DW-1:0] e_rd;
        logic          e_exec;
        logic [DW-1:0] e_a;
        logic [DW-1:0] e_b;
        logic [2:0]    e_op;
    } vec_t;

    vec_t tbl [13];
    int   order_exp [3];

    initial begin
        int waited;
        logic seen;

        tbl[0]  = '{1'b1, 1'b1, 5'd0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 3'd0};
        tbl[1]  = '{1'b1, 1'b1, 5'd1, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 3'd0};
        tbl[2]  = '{1'b1, 1'b1, 5'd2, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 3'd0};
        tbl[3]  = '{1'b1, 1'b1, 5'd3, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 3'd0};
        tbl[4]  = '{1'b1, 1'b0, 5'd4, 8'h12, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 3'd0};
        tbl[5]  = '{1'b1, 1'b0, 5'd5, 8'h34, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 3'd0};
        tbl[6]  = '{1'b1, 1'b0, 5'd6, 8'h0B, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 3'd0};
        tbl[7]  = '{1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h12, 8'h34, 3'd3};
        tbl[8]  = '{1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h12, 8'h34, 3'd3};
        tbl[9]  = '{1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 8'h46, 1'b0, 8'h00, 1'b0, 8'h12, 8'h34, 3'd3};
        tbl[10] = '{1'b1, 1'b1, 5'd7, 8'h00, 1'b0, 8'h00, 1'b1, 8'h46, 1'b0, 8'h12, 8'h34, 3'd3};
        tbl[11] = '{1'b1, 1'b1, 5'd6, 8'h00, 1'b0, 8'h00, 1'b1, 8'h23, 1'b0, 8'h12, 8'h34, 3'd3};
        tbl[12] = '{1'b1, 1'b1, 5'd6, 8'h00, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 8'h12, 8'h34, 3'd3};
        order_exp[0] = 2; order_exp[1] = 3; order_exp[2] = 0;

        model_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_rd", 32'(rd_data), 32'd0);
        chk("rst_A", 32'(A), 32'd0);
        chk("rst_B", 32'(B), 32'd0);
        chk("rst_oper", 32'(oper), 32'd0);
        chk("rst_exec", 32'(exec), 32'd0);
`ifdef ALU_REGBANK_IRQ_EN
        chk("rst_irq", 32'(irq), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Directed table: reset reads and a full ch1 operation.
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].en, tbl[i].rw, tbl[i].ad, tbl[i].wd, tbl[i].dn, tbl[i].res);
            chk($sformatf("tbl%0d_exec", i), 32'(exec), 32'(tbl[i].e_exec));
            chk($sformatf("tbl%0d_A", i), 32'(A), 32'(tbl[i].e_a));
            chk($sformatf("tbl%0d_B", i), 32'(B), 32'(tbl[i].e_b));
            chk($sformatf("tbl%0d_oper", i), 32'(oper), 32'(tbl[i].e_op));
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), 32'(rd_data), 32'(tbl[i].e_rd));
        end

        // Arbitration order while ch1 runs: gos to ch0, ch2, ch3.
        for (int c = 0; c < NC; c++) begin
            if (c != 1) cyc(1'b1, 1'b0, AW'(c * 4), DW'(8'h20 + c), 1'b0, '0);
        end
        cyc(1'b1, 1'b0, 5'd6, 8'h09, 1'b0, '0);
        idle();
        chk("arb_ch1_exec", 32'(exec), 32'd1);
        cyc(1'b1, 1'b0, 5'd2, 8'h0C, 1'b0, '0);
        cyc(1'b1, 1'b0, 5'd10, 8'h0D, 1'b0, '0);
        cyc(1'b1, 1'b0, 5'd14, 8'h0E, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, '0, '0, 1'b1, DW'(8'hA0 + k));
            seen = 1'b0;
            waited = 0;
            while (!seen && waited < 5) begin
                idle();
                seen = exec;
                waited++;
            end
            chk($sformatf("arb%0d_exec_seen", k), 32'(seen), 32'd1);
            chk($sformatf("arb%0d_order", k), 32'(A), 32'(8'h20 + order_exp[k]));
        end
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 8'h5A);

        // Go while busy sets err and preserves oper; a later idle go clears it.
        cyc(1'b1, 1'b0, 5'd2, 8'h0D, 1'b0, '0);
        idle();
        chk("err_exec", 32'(exec), 32'd1);
        cyc(1'b1, 1'b0, 5'd2, 8'h0A, 1'b0, '0);
        cyc(1'b1, 1'b0, 5'd2, 8'h0A, 1'b0, '0);
        cyc(1'b1, 1'b1, 5'd2, '0, 1'b0, '0);
        chk("err_status", 32'(rd_data), 32'h55);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 8'h77);
        cyc(1'b1, 1'b0, 5'd2, 8'h0A, 1'b0, '0);
        cyc(1'b1, 1'b1, 5'd2, '0, 1'b0, '0);
        chk("err_cleared_status", 32'(rd_data), 32'h12);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 8'h66);
        cyc(1'b1, 1'b1, 5'd2, '0, 1'b0, '0);
        chk("err_done_status", 32'(rd_data), 32'h22);

        // Reset while ch2 is running, then a stale alu_done.
        cyc(1'b1, 1'b0, 5'd10, 8'h0F, 1'b0, '0);
        idle();
        chk("rrun_exec", 32'(exec), 32'd1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rrun_exec_drop", 32'(exec), 32'd0);
        chk("rrun_A", 32'(A), 32'd0);
        chk("rrun_oper", 32'(oper), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 8'h99);
        for (int r = 0; r < 4; r++) begin
            cyc(1'b1, 1'b1, AW'(8 + r), '0, 1'b0, '0);
            chk($sformatf("rrun_reg%0d", r), 32'(rd_data), 32'd0);
        end

`ifdef ALU_REGBANK_IRQ_EN
        // irq from ch3 with ie set; a STATUS read drops it one cycle later.
        cyc(1'b1, 1'b0, 5'd14, 8'h89, 1'b0, '0);
        idle();
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 8'h55);
        idle();
        chk("irq_set", 32'(irq), 32'd1);
        cyc(1'b1, 1'b1, 5'd14, '0, 1'b0, '0);
        chk("irq_status", 32'(rd_data), 32'hA1);
        idle();
        chk("irq_clear", 32'(irq), 32'd0);
`endif

        // Randomized host and ALU traffic, including unmapped channels and stray alu_done.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom % 4) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)),
                DW'($urandom), ($urandom % 4) == 0, DW'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
